// File: rtl/math_multiplier_carrysave_pipe_pkg.sv
// Shared definitions for the pipelined carry-save multiplier.
// Holds the rows-per-stage split and the Baugh-Wooley correction constant.
// The per-stage payload struct is declared in the top module, because its
// field widths depend on the N parameter and a package cannot be parameterised.
package math_mult_pkg;

  // Widest operand supported. It sizes the correction-constant return value.
  localparam int MAX_N = 32;

  // Number of partial-product rows that each pipeline stage reduces.
  function automatic int rows_per_stage(input int n, input int stages);
    return (n + stages - 1) / stages;
  endfunction

  // Baugh-Wooley correction for an n x n signed product.
  // Complementing the mixed-sign terms leaves a residue of -2^(2n-1) + 2^n.
  // Modulo 2^(2n), that residue equals 2^(2n-1) + 2^n.
  function automatic logic [2*MAX_N-1:0] bw_correction(input int n);
    logic [2*MAX_N-1:0] c;
    c = '0;
    c[n] = 1'b1;
    c[2*n-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/math_multiplier_carrysave_pipe_csa_row.sv
// One N-bit carry-save row: a vector of full adders.
// It compresses three N-bit inputs into a sum vector and a carry vector.
// The carry vector is unshifted; the caller places it one column higher.
module math_csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] z_i,
  output logic [N-1:0] s_o,
  output logic [N-1:0] c_o
);

  assign s_o = x_i ^ y_i ^ z_i;
  assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);

endmodule

// File: rtl/math_multiplier_carrysave_pipe.sv
// Pipelined carry-save array multiplier with a valid/ready handshake on both sides.
// The tc input selects unsigned or two's-complement (Baugh-Wooley) mode for each operation.
// N partial-product rows are spread over STAGES register stages.
// The final carry-propagate merge happens in the last stage, which drives p.
// Optional accumulate mode is enabled by defining MATH_MULT_CARRYSAVE_ACC_EN.
module math_multiplier_carrysave_pipe
  import math_mult_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           tc,
  input  logic           acc_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  localparam int W2   = 2 * N;
  localparam int RPS  = rows_per_stage(N, STAGES);
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [2*MAX_N-1:0] BW_ALL   = bw_correction(N);
  localparam logic [W2-1:0]      BW_CONST = BW_ALL[W2-1:0];

  // Everything that travels with one operation between stages.
  typedef struct packed {
    logic [W2-1:0] sum;
    logic [W2-1:0] carry;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          tc;
    logic          acc_clr;
    logic          valid;
  } stage_t;

  stage_t        stage_in  [STAGES];
  stage_t        stage_out [STAGES];
  stage_t        stage_q   [NREG];
  logic [W2-1:0] row_sum   [N];
  logic [W2-1:0] row_carry [N];

  logic          out_valid_q;
  logic [W2-1:0] p_q;
  logic [W2-1:0] p_d;
  logic [W2-1:0] product;
  logic          advance;

  // The whole pipeline moves together; it freezes only when p is held by the consumer.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign p         = p_q;

  // Stage 0 starts from the correction constant (signed mode) and an empty carry vector.
  assign stage_in[0] = '{sum:     (tc ? BW_CONST : {W2{1'b0}}),
                         carry:   {W2{1'b0}},
                         a:       a,
                         b:       b,
                         tc:      tc,
                         acc_clr: acc_clr,
                         valid:   in_valid};

  for (genvar s = 1; s < STAGES; s++) begin : g_link
    assign stage_in[s] = stage_q[s-1];
  end

  // Row r adds partial product a*b[r], weighted by 2^r, into columns r..r+N-1.
  // Sum bits outside that window are either final or the correction constant.
  // All live carry bits lie inside the window, so only the row's own carries continue.
  for (genvar r = 0; r < N; r++) begin : g_row
    localparam int            S     = r / RPS;
    localparam logic [N-1:0]  MSB   = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  FLIP  = (r == N - 1) ? ~MSB : MSB;
    localparam logic [W2-1:0] WMASK = {{N{1'b0}}, {N{1'b1}}} << r;

    logic [W2-1:0] sum_in;
    logic [W2-1:0] carry_in;
    logic [N-1:0]  pp;
    logic [N-1:0]  win_s;
    logic [N-1:0]  win_c;

    if (r % RPS == 0) begin : g_first
      assign sum_in   = stage_in[S].sum;
      assign carry_in = stage_in[S].carry;
    end else begin : g_chain
      assign sum_in   = row_sum[r-1];
      assign carry_in = row_carry[r-1];
    end

    // Baugh-Wooley: in signed mode, invert the terms where exactly one factor is a sign bit.
    assign pp = (stage_in[S].a & {N{stage_in[S].b[r]}}) ^ (FLIP & {N{stage_in[S].tc}});

    math_csa_row #(.N(N)) u_row (
      .x_i (sum_in[r +: N]),
      .y_i (carry_in[r +: N]),
      .z_i (pp),
      .s_o (win_s),
      .c_o (win_c)
    );

    assign row_sum[r]   = (sum_in & ~WMASK) | ({{N{1'b0}}, win_s} << r);
    assign row_carry[r] = {{N{1'b0}}, win_c} << (r + 1);
  end

  // Each stage exposes the sum/carry state after its last row.
  // A stage that has no rows passes its payload through unchanged.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * RPS;
    localparam int LAST  = ((s + 1) * RPS < N) ? (s + 1) * RPS - 1 : N - 1;
    if (FIRST < N) begin : g_rows
      assign stage_out[s] = '{sum:     row_sum[LAST],
                              carry:   row_carry[LAST],
                              a:       stage_in[s].a,
                              b:       stage_in[s].b,
                              tc:      stage_in[s].tc,
                              acc_clr: stage_in[s].acc_clr,
                              valid:   stage_in[s].valid};
    end else begin : g_pass
      assign stage_out[s] = stage_in[s];
    end
  end

  // Vector-merge adder; wrapping modulo 2^(2N) is exactly what Baugh-Wooley needs.
  assign product = stage_out[STAGES-1].sum + stage_out[STAGES-1].carry;

  logic unused_tail;
  assign unused_tail = ^{stage_out[STAGES-1].a, stage_out[STAGES-1].b, stage_out[STAGES-1].tc};

`ifdef MATH_MULT_CARRYSAVE_ACC_EN
  logic [W2-1:0] acc_q;
  logic [W2-1:0] acc_d;

  assign acc_d = (stage_out[STAGES-1].acc_clr ? {W2{1'b0}} : acc_q) + product;
  assign p_d   = acc_d;

  // The running sum advances only when a real result enters the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (advance && stage_out[STAGES-1].valid) begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = stage_out[STAGES-1].acc_clr;
  assign p_d            = product;
`endif

  // Intermediate stage registers shift together whenever the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset along with the valid bits, so a bubble never carries X into the adders.
      for (int k = 0; k < NREG; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value on the same edge.
      for (int k = 0; k < STAGES - 1; k++) begin
        stage_q[k] <= stage_out[k];
      end
    end
  end

  // Output register: loads a merged result only for valid data and holds it while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else if (advance) begin
      out_valid_q <= stage_out[STAGES-1].valid;
      if (stage_out[STAGES-1].valid) begin
        p_q <= p_d;
      end
    end
  end

endmodule

// File: tb/tb_math_multiplier_carrysave_pipe.sv
// Self-checking bench for math_multiplier_carrysave_pipe.
// Two instances share one clock: N=4/STAGES=2 and N=16/STAGES=3.
// Expected results come from plain integer multiplication, plus a running sum
// when MATH_MULT_CARRYSAVE_ACC_EN is defined.
module tb_math_multiplier_carrysave_pipe;

  localparam int LAT4  = 2;
  localparam int LAT16 = 3;

  typedef struct {
    logic [63:0] p;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv4, ir4, tc4, clr4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  logic        iv16, ir16, tc16, clr16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  exp_t        q4[$];
  exp_t        q16[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          fire4, fire16;
  bit          lat_chk = 1'b1;
  bit          stall_chk = 1'b0;
  bit          rand_ready = 1'b0;
  bit          force_on = 1'b0;
  logic [63:0] force_exp;
`ifdef MATH_MULT_CARRYSAVE_ACC_EN
  logic [63:0] acc4 = '0;
  logic [63:0] acc16 = '0;
`endif

  always #5 clk = ~clk;

  math_multiplier_carrysave_pipe #(.N(4), .STAGES(2)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .in_valid (iv4), .in_ready (ir4),
    .a (a4), .b (b4), .tc (tc4), .acc_clr (clr4),
    .out_valid (ov4), .out_ready (or4), .p (p4)
  );

  math_multiplier_carrysave_pipe #(.N(16), .STAGES(3)) u_dut16 (
    .clk (clk), .rst_n (rst_n), .in_valid (iv16), .in_ready (ir16),
    .a (a16), .b (b16), .tc (tc16), .acc_clr (clr16),
    .out_valid (ov16), .out_ready (or16), .p (p16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Exact 2n-bit product of the two operands, read as signed when t is set.
  function automatic logic [63:0] ref_mul(input int n, input logic [31:0] x,
                                          input logic [31:0] y, input logic t);
    longint sx, sy;
    logic [63:0] m;
    sx = longint'(x);
    sy = longint'(y);
    if (t && x[n-1]) sx -= longint'(1) << n;
    if (t && y[n-1]) sy -= longint'(1) << n;
    m = (n >= 32) ? {64{1'b1}} : ((64'd1 << (2 * n)) - 64'd1);
    return 64'(sx * sy) & m;
  endfunction

  // One clock cycle: sample both sides just after the negedge, score any
  // transfers due at the coming posedge, then move to the next negedge.
  task automatic tick();
    exp_t        e;
    logic [63:0] v;
    if (rand_ready) or16 = ($urandom_range(0, 3) != 0);
    #1;
    fire4  = 1'b0;
    fire16 = 1'b0;
    if (stall_chk) begin
      check("stall_in_ready", 64'(ir4), 64'd0);
      check("stall_out_valid", 64'(ov4), 64'd1);
      if (q4.size() > 0) check("stall_p_held", 64'(p4), q4[0].p);
    end
    if (ov4 && or4) begin
      if (q4.size() == 0) check("d4_unexpected_result", 64'(ov4), 64'd0);
      else begin
        e = q4.pop_front();
        check("d4_p", 64'(p4), e.p);
        if (lat_chk) check("d4_latency", 64'(cyc - e.cyc), 64'(LAT4));
      end
    end
    if (ov16 && or16) begin
      if (q16.size() == 0) check("d16_unexpected_result", 64'(ov16), 64'd0);
      else begin
        e = q16.pop_front();
        check("d16_p", 64'(p16), e.p);
        if (lat_chk) check("d16_latency", 64'(cyc - e.cyc), 64'(LAT16));
      end
    end
    if (iv4 && ir4) begin
      fire4 = 1'b1;
      v = ref_mul(4, 32'(a4), 32'(b4), tc4);
`ifdef MATH_MULT_CARRYSAVE_ACC_EN
      acc4 = ((clr4 ? 64'd0 : acc4) + v) & 64'hFF;
      v = acc4;
`endif
      if (force_on) begin
        v = force_exp;
        force_on = 1'b0;
      end
      q4.push_back('{p: v, cyc: cyc});
    end
    if (iv16 && ir16) begin
      fire16 = 1'b1;
      v = ref_mul(16, 32'(a16), 32'(b16), tc16);
`ifdef MATH_MULT_CARRYSAVE_ACC_EN
      acc16 = ((clr16 ? 64'd0 : acc16) + v) & 64'hFFFF_FFFF;
      v = acc16;
`endif
      if (force_on) begin
        v = force_exp;
        force_on = 1'b0;
      end
      q16.push_back('{p: v, cyc: cyc});
    end
    @(negedge clk);
    cyc++;
  endtask

  // Present one operation and hold it until it is accepted (bounded).
  task automatic send(input int which, input logic [15:0] x, input logic [15:0] y,
                      input logic t, input logic c);
    bit got;
    got = 1'b0;
    if (which == 4) begin
      iv4 = 1'b1; a4 = x[3:0]; b4 = y[3:0]; tc4 = t; clr4 = c;
    end else begin
      iv16 = 1'b1; a16 = x; b16 = y; tc16 = t; clr16 = c;
    end
    for (int k = 0; k < 64 && !got; k++) begin
      tick();
      got = (which == 4) ? fire4 : fire16;
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_exp(input int which, input logic [15:0] x, input logic [15:0] y,
                          input logic t, input logic c, input logic [63:0] exp);
    force_on  = 1'b1;
    force_exp = exp;
    send(which, x, y, t, c);
  endtask

  task automatic drain();
    iv4  = 1'b0;
    iv16 = 1'b0;
    for (int k = 0; k < 400 && (q4.size() > 0 || q16.size() > 0); k++) tick();
    check("drain_timeout", 64'(q4.size() + q16.size()), 64'd0);
    repeat (4) tick();
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; tc4 = 1'b0; clr4 = 1'b1; or4 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; tc16 = 1'b0; clr16 = 1'b1; or16 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid4", 64'(ov4), 64'd0);
    check("rst_p4", 64'(p4), 64'd0);
    check("rst_out_valid16", 64'(ov16), 64'd0);
    check("rst_p16", 64'(p16), 64'd0);
    check("rst_in_ready4", 64'(ir4), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive unsigned, back-to-back: one acceptance per cycle.
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) send(4, 16'(i), 16'(j), 1'b0, 1'b1);
    check("d4_throughput_unsigned", 64'(cyc - c0), 64'd256);
    drain();

    // Exhaustive signed, plus the two extreme corner products.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) send(4, 16'(i), 16'(j), 1'b1, 1'b1);
    send_exp(4, 16'h8, 16'h8, 1'b1, 1'b1, 64'h40);
    send_exp(4, 16'h8, 16'h7, 1'b1, 1'b1, 64'hC8);
    drain();

    // Stall: the consumer backs off for five cycles while new input waits.
    lat_chk = 1'b0;
    send(4, 16'd1, 16'd2, 1'b0, 1'b1);
    send(4, 16'd3, 16'd4, 1'b0, 1'b1);
    send(4, 16'd5, 16'd6, 1'b0, 1'b1);
    iv4 = 1'b1; a4 = 4'd7; b4 = 4'd9; tc4 = 1'b0; clr4 = 1'b1; or4 = 1'b0;
    stall_chk = 1'b1;
    repeat (5) tick();
    stall_chk = 1'b0;
    or4 = 1'b1;
    send(4, 16'd7, 16'd9, 1'b0, 1'b1);
    drain();
    lat_chk = 1'b1;

    // Reset with two operations in flight: both must vanish.
    send(4, 16'd2, 16'd3, 1'b0, 1'b1);
    send(4, 16'd4, 16'd5, 1'b0, 1'b1);
    iv4 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid4", 64'(ov4), 64'd0);
    check("midrst_p4", 64'(p4), 64'd0);
    check("midrst_out_valid16", 64'(ov16), 64'd0);
    q4.delete();
    q16.delete();
`ifdef MATH_MULT_CARRYSAVE_ACC_EN
    acc4 = '0;
    acc16 = '0;
`endif
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    cyc++;
    send_exp(4, 16'd3, 16'd5, 1'b0, 1'b1, 64'd15);
    drain();

    // Wide operands and boundary values on the 16-bit instance.
    send_exp(16, 16'hF00D, 16'h0DAD, 1'b0, 1'b1, 64'h0CD2_E1C9);
    send_exp(16, 16'hF00D, 16'h0DAD, 1'b1, 1'b1, 64'hFF25_E1C9);
    send_exp(16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 64'hFFFE_0001);
    send_exp(16, 16'h8000, 16'h8000, 1'b1, 1'b1, 64'h4000_0000);
    send(16, 16'h0000, 16'hBEEF, 1'b1, 1'b1);
    send(16, 16'h1234, 16'h0000, 1'b0, 1'b1);
    send(16, 16'h8000, 16'h7FFF, 1'b1, 1'b1);
    drain();

    // Random operands, mixed tc in flight, random consumer back-pressure.
    lat_chk = 1'b0;
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++)
      send(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    rand_ready = 1'b0;
    or16 = 1'b1;
    drain();
    lat_chk = 1'b1;

    // Accumulate sequence; without the feature each p is the bare product.
`ifdef MATH_MULT_CARRYSAVE_ACC_EN
    send_exp(16, 16'd3, 16'd4, 1'b0, 1'b1, 64'd12);
    send_exp(16, 16'd2, 16'd5, 1'b0, 1'b0, 64'd22);
    send_exp(16, 16'd255, 16'd255, 1'b0, 1'b0, 64'd65047);
    send_exp(16, 16'd1, 16'd1, 1'b0, 1'b1, 64'd1);
`else
    send_exp(16, 16'd3, 16'd4, 1'b0, 1'b1, 64'd12);
    send_exp(16, 16'd2, 16'd5, 1'b0, 1'b0, 64'd10);
    send_exp(16, 16'd255, 16'd255, 1'b0, 1'b0, 64'd65025);
    send_exp(16, 16'd1, 16'd1, 1'b0, 1'b1, 64'd1);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
